// File: rtl/ctrl_fetch_pkg.sv
// Shared types and widths for the control-word fetch streamer.
package ctrl_fetch_pkg;

  localparam int CTRL_DATA_WIDTH = 72;
  localparam int CTRL_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ctrl_fetch_fifo.sv
// Synchronous FIFO for fetched control words; head reads as zero while empty.
module ctrl_fetch_fifo
  import ctrl_fetch_pkg::*;
#(
  parameter int WIDTH = CTRL_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk0,
  input  logic                     rst0,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign pop_ok_s  = pop && (count_r != (PW+1)'(0));
  assign push_ok_s = push && ((count_r != (PW+1)'(DEPTH)) || pop_ok_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk0) begin
    if (rst0 || clr) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk0) begin
    if (push_ok_s && !clr && !rst0) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign count = count_r;
  assign head  = (count_r != (PW+1)'(0)) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

endmodule

// File: rtl/ctrl_fetch_streamer.sv
// Reads an inclusive, wrapping SRAM address range into a FIFO and streams it out.
// Optional macro CTRL_FETCH_ABORT_EN adds an abort input that flushes a running fetch.
module ctrl_fetch_streamer
  import ctrl_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = CTRL_DATA_WIDTH,
  parameter int ADDR_WIDTH = CTRL_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
`ifdef CTRL_FETCH_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state_r;
  fetch_state_t          state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH:0]   remaining_r;
  logic                  rd_pending_r;
  logic                  busy_r;
  logic                  done_r;
  logic [CW-1:0]         fifo_count_s;
  logic [CW-1:0]         occ_next_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  abort_s;
  logic                  flush_s;
  logic                  credit_s;
  logic                  issue_s;
  logic                  last_pop_s;

`ifdef CTRL_FETCH_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // A read is only issued when its word is guaranteed a FIFO slot on return.
  assign valid_s    = (fifo_count_s != CW'(0));
  assign pop_s      = valid_s && out_ready;
  assign flush_s    = abort_s && (state_r != IDLE);
  assign occ_next_s = fifo_count_s - CW'(pop_s);
  assign credit_s   = (occ_next_s + CW'(rd_pending_r)) < CW'(FIFO_DEPTH);
  assign issue_s    = (state_r == FETCH) && !flush_s && credit_s;
  assign last_pop_s = (state_r == DRAIN) && pop_s && !rd_pending_r &&
                      (fifo_count_s == CW'(1));

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = FETCH;
        else       state_s = IDLE;
      end
      FETCH: begin
        if (flush_s)                                              state_s = IDLE;
        else if (issue_s && (remaining_r == (ADDR_WIDTH+1)'(1))) state_s = DRAIN;
        else                                                      state_s = FETCH;
      end
      DRAIN: begin
        if (flush_s || last_pop_s) state_s = IDLE;
        else                       state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, address counter and status registers.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      remaining_r  <= {(ADDR_WIDTH+1){1'b0}};
      rd_pending_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != IDLE);
      done_r       <= last_pop_s && !flush_s;
      rd_pending_r <= issue_s;
      if ((state_r == IDLE) && start) begin
        addr_r      <= start_addr;
        remaining_r <= {1'b0, end_addr - start_addr} + (ADDR_WIDTH+1)'(1);
      end else if (issue_s) begin
        addr_r      <= addr_r + ADDR_WIDTH'(1);
        remaining_r <= remaining_r - (ADDR_WIDTH+1)'(1);
      end else begin
        addr_r      <= addr_r;
        remaining_r <= remaining_r;
      end
    end
  end

  // The macro holds dout0 while deselected, so only rd_pending qualifies a push.
  ctrl_fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk0      (clk0),
    .rst0      (rst0),
    .clr       (flush_s),
    .push      (rd_pending_r),
    .push_data (mem_dout0),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_csb0  = !issue_s;
  assign mem_web0  = 1'b1;
  assign mem_addr0 = issue_s ? addr_r : {ADDR_WIDTH{1'b0}};
  assign mem_din0  = {DATA_WIDTH{1'b0}};
  assign out_valid = valid_s;
  assign out_data  = fifo_head_s;

endmodule

// File: doc/ctrl_fetch_streamer.md
# ctrl_fetch_streamer

Read-side sequencer for the 72-bit x 4096 control-word SRAM. On a start command it reads an address range from the SRAM's single RW port and places each word in a small output FIFO, then presents the words as a valid/ready stream to the control decoder downstream. It owns the SRAM port exclusively while busy, tracks the macro's one-cycle registered read latency, and never overruns its FIFO.

## Interface
- DATA_WIDTH, 72, control word width
- ADDR_WIDTH, 12, SRAM address width (depth 1<<ADDR_WIDTH)
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2; 4 or more for 1 word/cycle
- clk0  in  1  clock; all logic on posedge
- rst0  in  1  synchronous, active-high reset
- start  in  1  begin a fetch; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first address
- end_addr  in  ADDR_WIDTH  last address, inclusive
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the final word is accepted downstream
- mem_csb0  out  1  SRAM chip select, active low
- mem_web0  out  1  SRAM write enable, active low; held 1 (read-only master)
- mem_addr0  out  ADDR_WIDTH  SRAM address
- mem_din0  out  DATA_WIDTH  held 0
- mem_dout0  in  DATA_WIDTH  SRAM read data, valid the cycle after a read is issued
- out_valid  out  1  stream word available
- out_data  out  DATA_WIDTH  stream word
- out_ready  in  1  downstream accepts when high with out_valid

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE, start=1: latch addresses, set remaining = ((end_addr - start_addr) mod 2^ADDR_WIDTH) + 1, go to FETCH. If start_addr == end_addr, exactly 1 word is read. Addresses wrap from 4095 to 0, so end_addr < start_addr is a wrapped range.
- FETCH: issue a read (mem_csb0=0, mem_web0=1, mem_addr0=current) in every cycle where occupancy_next + inflight < FIFO_DEPTH.
  - occupancy_next is the FIFO count after this cycle's pop.
  - inflight counts reads issued but not yet written into the FIFO (0 or 1).
  - Each issue increments the address modulo 2^ADDR_WIDTH and decrements remaining. Go to DRAIN after the last issue.
- Capture: a registered rd_pending flag marks the cycle in which mem_dout0 is valid. mem_dout0 is written into the FIFO only in that cycle. Because the macro holds dout0 while deselected, data is never captured without rd_pending.
- DRAIN: issue no reads. When the last word pops (out_valid & out_ready), pulse done, drop busy, and return to IDLE.
- start while busy is ignored.
- The FIFO never overflows. Push and pop in the same cycle leaves occupancy unchanged.
- out_data is the FIFO head and is held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: busy 0, done 0, out_valid 0, out_data 0, mem_csb0 1, mem_web0 1, mem_addr0 0, mem_din0 0. Reset also clears the FIFO, inflight, rd_pending and the state (IDLE).
- rst0 mid-fetch: all state is cleared on that edge. A word returning from an in-flight read is discarded.
- Latency, with start in cycle 0:
  - cycle 1: mem_csb0=0 and busy=1
  - cycle 2: mem_dout0 valid
  - cycle 3: out_valid=1
- Throughput: with out_ready held 1 and FIFO_DEPTH>=4, one word per cycle.
- done pulses in the cycle after the final handshake. A new start is accepted from that same cycle.

## Configuration
- CTRL_FETCH_ABORT_EN defined: adds the input port abort (1 bit).
  - abort=1 while busy: stop issuing, discard any inflight word, flush the FIFO. out_valid is 0 the next cycle, busy drops, done is not pulsed, and the state returns to IDLE.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Undefined: no abort port; a fetch always runs to completion or to rst0.

## Structure
- Shared package ctrl_fetch_pkg holds:
  - the state enum type (IDLE/FETCH/DRAIN)
  - CTRL_DATA_WIDTH=72 and CTRL_ADDR_WIDTH=12
- Sub-module ctrl_fetch_fifo: synchronous FIFO, parameterised width/depth, with push/pop/count/head. The top holds the FSM, address counter and credit logic.

## Test plan
- Range 0x010..0x013, out_ready=1: 4 words from addresses 0x010–0x013 in order; out_valid first in cycle 3; done one cycle after the 4th handshake.
- Wrap range 0xFFE..0x001: addresses 0xFFE, 0xFFF, 0x000, 0x001 issued; exactly 4 words out.
- start_addr = end_addr = 0x7A5: one read, one word, done pulses; mem_csb0 low for exactly 1 cycle.
- Range 0..31 with out_ready toggling pseudo-randomly: no loss or duplication, out_data stable under stall, occupancy never exceeds FIFO_DEPTH, mem_csb0 stays 1 while the FIFO is full.
- rst0 asserted on the 5th word of 0..15: all outputs at reset values next cycle; a following start 0x100..0x101 yields exactly 2 correct words.
- (CTRL_FETCH_ABORT_EN) abort while a read is in flight and FIFO holds 2: out_valid 0 and busy 0 next cycle, no done, no stale word on the next fetch.
